link_burst_master: RTL and testbench

//   Parametrised successor to the single-word link master: moves a burst of

---
 rtl/link_burst_master_pkg.sv | 22 ++
 rtl/link_burst_master_timeout_ctr.sv | 40 ++++
 rtl/link_burst_master.sv | 129 ++++++++++++
 tb/tb_link_burst_master.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/link_burst_master_pkg.sv
// Shared types and default parameters for the burst link master.
package link_burst_master_pkg;

  localparam int unsigned DataWDef    = 8;
  localparam int unsigned BurstLenDef = 4;
  localparam int unsigned TimeoutDef  = 16;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFetch = 3'd1,
    StReq   = 3'd2,
    StDrop  = 3'd3,
    StDone  = 3'd4,
    StErr   = 3'd5
  } state_e;

  // A burst is in flight from the first fetch up to and including the done cycle.
  function automatic logic state_is_busy(input state_e s);
    return (s == StFetch) || (s == StReq) || (s == StDrop) || (s == StDone);
  endfunction

endpackage

// File: rtl/link_burst_master_timeout_ctr.sv
// Wait-cycle counter for one handshake phase; flags expiry on the last allowed cycle.
module link_burst_master_timeout_ctr #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] MaxVal = CntW'(TIMEOUT - 1);
  // The count reaches TIMEOUT-1 at the end of the cycle whose current value is TIMEOUT-2.
  localparam logic [CntW-1:0] ExpVal = CntW'(TIMEOUT - 2);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Clear wins over count; saturate so a stalled FSM cannot wrap back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != MaxVal)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == ExpVal);

endmodule

// File: rtl/link_burst_master.sv
// Burst master: fetches BURST_LEN words from a valid/ready source and sends each
// over a 4-phase req/ack link, with per-phase ack timeout and a sticky error.
module link_burst_master
  import link_burst_master_pkg::*;
#(
  parameter int unsigned DATA_W    = DataWDef,
  parameter int unsigned BURST_LEN = BurstLenDef,
  parameter int unsigned TIMEOUT   = TimeoutDef,
  localparam int unsigned CntW     = $clog2(BURST_LEN + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [DATA_W-1:0] src_data_i,
  input  logic              src_valid_i,
  output logic              src_ready_o,
  output logic              req_o,
  input  logic              ack_i,
  output logic [DATA_W-1:0] data_o,
  output logic              busy_o,
  output logic [CntW-1:0]   word_cnt_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [CntW-1:0] LastIdx = CntW'(BURST_LEN - 1);

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CntW-1:0]   wc_q, wc_d;
  logic              tmo_clr, tmo_en, tmo_expired;

  link_burst_master_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (tmo_clr),
    .en_i      (tmo_en),
    .expired_o (tmo_expired)
  );

  // Next-state, capture and bookkeeping for the burst FSM.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    wc_d    = wc_q;
    err_d   = err_q;
    tmo_clr = 1'b0;
    tmo_en  = 1'b0;
    unique case (state_q)
      StIdle, StErr: begin
        if (start_i) begin
          state_d = StFetch;
          wc_d    = '0;
          err_d   = 1'b0;
        end
      end
      StFetch: begin
        if (src_valid_i) begin
          data_d  = src_data_i;
          state_d = StReq;
          tmo_clr = 1'b1;
        end
      end
      StReq: begin
        tmo_en = 1'b1;
        // An ack in the expiry cycle still counts as success.
        if (ack_i) begin
          state_d = StDrop;
          tmo_clr = 1'b1;
        end else if (tmo_expired) begin
          state_d = StErr;
          err_d   = 1'b1;
        end
      end
      StDrop: begin
        tmo_en = 1'b1;
        if (!ack_i) begin
          wc_d    = wc_q + CntW'(1);
          state_d = (wc_q == LastIdx) ? StDone : StFetch;
        end else if (tmo_expired) begin
          state_d = StErr;
          err_d   = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // req and done are registered copies of the state being entered.
    req_d  = (state_d == StReq);
    done_d = (state_d == StDone);
  end

  // State and output registers; reset drops req at once and reports nothing.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      wc_q    <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      done_q  <= done_d;
      err_q   <= err_d;
      data_q  <= data_d;
      wc_q    <= wc_d;
    end
  end

  assign src_ready_o = (state_q == StFetch);
  assign req_o       = req_q;
  assign data_o      = data_q;
  assign busy_o      = state_is_busy(state_q);
  assign word_cnt_o  = wc_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_link_burst_master.sv
// Bench for link_burst_master: two instances (default and single-word 16-bit),
// each paired with an ack responder of programmable latency.
module tb_link_burst_master;

  logic clk;
  logic rst_n;

  // Default instance (DATA_W=8, BURST_LEN=4, TIMEOUT=16).
  logic       start0, sv0, sr0, req0, ack0, busy0, done0, err0;
  logic [7:0] sd0, data0;
  logic [2:0] wc0;
  // Single-word instance (DATA_W=16, BURST_LEN=1).
  logic        start1, sv1, sr1, req1, ack1, busy1, done1, err1;
  logic [15:0] sd1, data1;
  logic [0:0]  wc1;

  int  lat0, lat1;
  logic en0, en1;

  int cmp_cnt;
  int mis_cnt;
  int done_cnt0, done_cnt1, rise0;
  logic [7:0]  exp0[$];
  logic [15:0] exp1[$];
  logic [2:0]  expd0[$];

  link_burst_master u_dut0 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start0),
    .src_data_i  (sd0),
    .src_valid_i (sv0),
    .src_ready_o (sr0),
    .req_o       (req0),
    .ack_i       (ack0),
    .data_o      (data0),
    .busy_o      (busy0),
    .word_cnt_o  (wc0),
    .done_o      (done0),
    .err_o       (err0)
  );

  link_burst_master #(
    .DATA_W    (16),
    .BURST_LEN (1),
    .TIMEOUT   (16)
  ) u_dut1 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start1),
    .src_data_i  (sd1),
    .src_valid_i (sv1),
    .src_ready_o (sr1),
    .req_o       (req1),
    .ack_i       (ack1),
    .data_o      (data1),
    .busy_o      (busy1),
    .word_cnt_o  (wc1),
    .done_o      (done1),
    .err_o       (err1)
  );

  // Responders: ack is seen in the lat-th req-high cycle and falls one cycle after req.
  int   hi0, hi1;
  logic hold0, hold1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi0 <= 0; hold0 <= 1'b0; hi1 <= 0; hold1 <= 1'b0;
    end else begin
      hi0   <= req0 ? hi0 + 1 : 0;
      hold0 <= ack0 && req0;
      hi1   <= req1 ? hi1 + 1 : 0;
      hold1 <= ack1 && req1;
    end
  end
  assign ack0 = hold0 || (en0 && req0 && (hi0 >= lat0 - 1));
  assign ack1 = hold1 || (en1 && req1 && (hi1 >= lat1 - 1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    cmp_cnt++;
    if (act !== expv) begin
      mis_cnt++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Scoreboard monitor: pops expected data on each req rise, expected count on done.
  task automatic monitor();
    logic rp0, rp1;
    rp0 = 1'b0;
    rp1 = 1'b0;
    forever begin
      @(negedge clk);
      if (req0 && !rp0) begin
        rise0++;
        if (exp0.size() == 0) chk("req0_unexpected", 32'(exp0.size()), 32'd1);
        else chk("req0_data", 32'(data0), 32'(exp0.pop_front()));
      end
      if (done0) begin
        done_cnt0++;
        if (expd0.size() == 0) chk("done0_unexpected", 32'(expd0.size()), 32'd1);
        else begin
          chk("done0_wc", 32'(wc0), 32'(expd0.pop_front()));
          chk("done0_err", 32'(err0), 32'd0);
        end
      end
      if (req1 && !rp1) begin
        if (exp1.size() == 0) chk("req1_unexpected", 32'(exp1.size()), 32'd1);
        else chk("req1_data", 32'(data1), 32'(exp1.pop_front()));
      end
      if (done1) begin
        done_cnt1++;
        chk("done1_wc", 32'(wc1), 32'd1);
      end
      rp0 = req0;
      rp1 = req1;
    end
  endtask

  // Wait for src_ready, optionally hold src_valid low, then hand over one word.
  task automatic feed0(input logic [7:0] w, input int stall);
    int n;
    n = 0;
    while (!sr0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("feed0_ready", 32'(sr0), 32'd1);
    for (int i = 0; i < stall; i++) begin
      chk("stall_ready", 32'(sr0), 32'd1);
      chk("stall_req", 32'(req0), 32'd0);
      @(negedge clk);
    end
    exp0.push_back(w);
    sv0 = 1'b1;
    sd0 = w;
    @(negedge clk);
    sv0 = 1'b0;
  endtask

  task automatic burst0(input logic [31:0] ws, input int nw, input int stall_idx,
                        input int stall_n, input bit expect_done);
    if (expect_done) expd0.push_back(3'd4);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("start_err_clr", 32'(err0), 32'd0);
    chk("start_wc_clr", 32'(wc0), 32'd0);
    chk("start_busy", 32'(busy0), 32'd1);
    for (int i = 0; i < nw; i++) begin
      feed0(ws[31-8*i -: 8], (i == stall_idx) ? stall_n : 0);
    end
  endtask

  task automatic finish0(input int dones_exp);
    int n;
    n = 0;
    while (busy0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("idle0", 32'(busy0), 32'd0);
    chk("end_wc", 32'(wc0), 32'd4);
    chk("end_err", 32'(err0), 32'd0);
    chk("end_done_cnt", 32'(done_cnt0), 32'(dones_exp));
    chk("end_sb_empty", 32'(exp0.size()), 32'd0);
  endtask

  initial begin
    int n;
    cmp_cnt = 0; mis_cnt = 0; done_cnt0 = 0; done_cnt1 = 0; rise0 = 0;
    rst_n = 1'b0;
    start0 = 1'b0; sv0 = 1'b0; sd0 = '0;
    start1 = 1'b0; sv1 = 1'b0; sd1 = '0;
    lat0 = 1; en0 = 1'b1; lat1 = 1; en1 = 1'b1;
    fork
      monitor();
    join_none

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(req0), 32'd0);
    chk("rst_data", 32'(data0), 32'd0);
    chk("rst_wc", 32'(wc0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_ready", 32'(sr0), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: plain burst, latency 1.
    burst0(32'hA1B2C3D4, 4, -1, 0, 1'b1);
    finish0(1);
    chk("t1_req_pulses", 32'(rise0), 32'd4);

    // 2: source stalls 5 cycles before word 2.
    burst0(32'h11223344, 4, 1, 5, 1'b1);
    finish0(2);

    // 3: slave never acks.
    en0 = 1'b0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    feed0(8'h5A, 0);
    n = 0;
    while (req0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t3_req_len", 32'(n), 32'd15);
    chk("t3_err", 32'(err0), 32'd1);
    chk("t3_req_low", 32'(req0), 32'd0);
    chk("t3_busy", 32'(busy0), 32'd0);
    chk("t3_data_hold", 32'(data0), 32'h5A);
    repeat (3) @(negedge clk);
    chk("t3_err_sticky", 32'(err0), 32'd1);
    chk("t3_no_done", 32'(done_cnt0), 32'd2);
    en0 = 1'b1;
    burst0(32'hE1E2E3E4, 4, -1, 0, 1'b1);
    finish0(3);

    // 4: ack arrives in the expiry cycle.
    lat0 = 15;
    burst0(32'h0F1E2D3C, 4, -1, 0, 1'b1);
    finish0(4);
    lat0 = 1;

    // 5: reset while word 3 is in REQ.
    burst0(32'h01020300, 3, -1, 0, 1'b0);
    chk("t5_in_req", 32'(req0), 32'd1);
    chk("t5_pre_wc", 32'(wc0), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_req", 32'(req0), 32'd0);
    chk("t5_rst_wc", 32'(wc0), 32'd0);
    chk("t5_rst_busy", 32'(busy0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    burst0(32'h61626364, 4, -1, 0, 1'b1);
    finish0(5);

    // 6: single-word, 16-bit instance.
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("t6_ready", 32'(sr1), 32'd1);
    exp1.push_back(16'hBEEF);
    sv1 = 1'b1;
    sd1 = 16'hBEEF;
    @(negedge clk);
    sv1 = 1'b0;
    n = 0;
    while (busy1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t6_idle", 32'(busy1), 32'd0);
    chk("t6_data", 32'(data1), 32'hBEEF);
    chk("t6_wc", 32'(wc1), 32'd1);
    chk("t6_done_cnt", 32'(done_cnt1), 32'd1);
    chk("t6_err", 32'(err1), 32'd0);
    chk("t6_sb_empty", 32'(exp1.size()), 32'd0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
